dffnsnq_bist_ctrl: RTL

- Built-in self-test controller that drives one negative-edge, set-on-low D flip-flop cell (dffnsnq-class) and checks its Q output against an internal behavioural model.
- Generates the DUT's clock, data and set-low stimulus from a 16-bit LFSR and counts mismatches.
- Instantiated beside a cell under test in characterisation and silicon-debug test structures; fully synchronous to CLK apart from the reset.

---
 rtl/dffnsnq_bist_ctrl_if.sv | 26 ++
 rtl/dffnsnq_bist_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dffnsnq_bist_ctrl_if.sv
// Bus between the dffnsnq BIST controller and its environment: run control,
// status, and the stimulus/response pins of the cell under test.
interface dffnsnq_bist_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             START;
  logic             DUT_Q;
  logic             DUT_CLKN;
  logic             DUT_D;
  logic             DUT_SETN;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] FIRST_FAIL_IDX;

  modport master (
    output START, DUT_Q,
    input  DUT_CLKN, DUT_D, DUT_SETN, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL_IDX
  );

  modport slave (
    input  START, DUT_Q,
    output DUT_CLKN, DUT_D, DUT_SETN, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL_IDX
  );
endinterface

// File: rtl/dffnsnq_bist_ctrl.sv
// BIST controller for a negative-edge, set-on-low D flip-flop cell: LFSR-driven
// 4-phase stimulus per vector, response check against a behavioural model.
module dffnsnq_bist_ctrl #(
  parameter int unsigned NUM_VEC = 256,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned CNT_W   = 16
) (
  input logic                CLK,
  input logic                RN,
  dffnsnq_bist_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0]      LAST_VEC = 16'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [15:0]      vec_q, vec_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             clkn_q, clkn_d;
  logic             dout_q, dout_d;
  logic             setn_q, setn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [15:0] lfsr_nx_s;
  logic        exp_s;
  logic        miss_s;

  // Fibonacci taps 16,14,13,11; the expected Q honours the asynchronous set.
  assign lfsr_nx_s = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign exp_s     = setn_q ? dout_q : 1'b1;
  assign miss_s    = (bus.DUT_Q != exp_s);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vec_d   = vec_q;
    lfsr_d  = lfsr_q;
    clkn_d  = clkn_q;
    dout_d  = dout_q;
    setn_d  = setn_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d = S_RUN;
          phase_d = 2'd0;
          vec_d   = 16'd0;
          lfsr_d  = SEED;
          clkn_d  = 1'b1;
          dout_d  = SEED[0];
          setn_d  = (SEED[3:1] != 3'b000);
          err_d   = {CNT_W{1'b0}};
          ffi_d   = CNT_MAX;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        case (phase_q)
          2'd0: begin
            clkn_d  = 1'b0;
            phase_d = 2'd1;
          end
          2'd1: phase_d = 2'd2;
          2'd2: begin
            clkn_d  = 1'b1;
            phase_d = 2'd3;
          end
          2'd3: begin
            if (miss_s) begin
              err_d = (err_q == CNT_MAX) ? CNT_MAX : err_q + CNT_ONE;
              ffi_d = (ffi_q == CNT_MAX) ? CNT_W'(vec_q) : ffi_q;
            end else begin
              err_d = err_q;
            end
            lfsr_d = lfsr_nx_s;
            vec_d  = vec_q + 16'd1;
            // Last vector parks the cell in the set state.
            if (vec_q == LAST_VEC) begin
              state_d = S_DONE;
              clkn_d  = 1'b1;
              dout_d  = 1'b0;
              setn_d  = 1'b0;
              pass_d  = (err_d == {CNT_W{1'b0}});
            end else begin
              phase_d = 2'd0;
              dout_d  = lfsr_nx_s[0];
              setn_d  = (lfsr_nx_s[3:1] != 3'b000);
            end
          end
          default: phase_d = 2'd0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      vec_q   <= 16'd0;
      lfsr_q  <= SEED;
      clkn_q  <= 1'b1;
      dout_q  <= 1'b0;
      setn_q  <= 1'b0;
      err_q   <= {CNT_W{1'b0}};
      ffi_q   <= CNT_MAX;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vec_q   <= vec_d;
      lfsr_q  <= lfsr_d;
      clkn_q  <= clkn_d;
      dout_q  <= dout_d;
      setn_q  <= setn_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.DUT_CLKN       = clkn_q;
  assign bus.DUT_D          = dout_q;
  assign bus.DUT_SETN       = setn_q;
  assign bus.BUSY           = busy_q;
  assign bus.DONE           = done_q;
  assign bus.PASS           = pass_q;
  assign bus.ERR_CNT        = err_q;
  assign bus.FIRST_FAIL_IDX = ffi_q;

endmodule
